// File: rtl/four_digit_scan_decoder.sv
// -----------------------------------------------------------------------------
// four_digit_scan_decoder
//
// Receive side of a 4-digit multiplexed 7-segment display bus. The anode,
// segment and decimal-point lines are sampled and debounced. Each digit's
// segment pattern is decoded back to a hex value, and a complete 3-2-1-0 scan
// is published as one frame with a single-cycle valid pulse. The block is
// meant to run as a loopback monitor next to the scan driver, in the same
// clock domain.
//
// Ports
//   clk                 in   system clock (same domain as the scan driver)
//   reset               in   synchronous, active-high
//   an3, an2, an1, an0  in   anode enables, active-low
//   A .. G              in   segment lines, active-low, A is the MSB of a pattern
//   dp                  in   decimal point, active-low (only reported in frame_dp)
//   digit3 .. digit0    out  hex value of each digit in the last complete frame
//   frame_dp            out  {3,2,1,0} decimal point state in the last frame, 1 = lit
//   frame_valid         out  one-cycle pulse; digitN/frame_dp change in this cycle
//   seg_err             out  one-cycle pulse: captured pattern is not a hex glyph
//   seq_err             out  one-cycle pulse: multi-hot anodes or digit out of order
//   timeout             out  one-cycle pulse: TIMEOUT_CYCLES without a frame
// -----------------------------------------------------------------------------
module four_digit_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       an3,
    input  logic       an2,
    input  logic       an1,
    input  logic       an0,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       D,
    input  logic       E,
    input  logic       F,
    input  logic       G,
    input  logic       dp,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic [3:0] frame_dp,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       seq_err,
    output logic       timeout
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_EXP3,
        ST_EXP2,
        ST_EXP1,
        ST_EXP0
    } state_t;

    // Segment pattern (A..G, active-low, A = MSB) to {valid, hex value}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Input sampling register and settle tracking
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [11:0]      sample;
    logic [11:0]      prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed;
    logic             capture;

    // Classification / decode of the registered sample
    logic             an_blank;
    logic             an_multi;
    logic [1:0]       an_k;
    logic [4:0]       dec;
    logic             seg_ok;
    logic [3:0]       seg_val;
    logic             dp_lit;
    logic [1:0]       exp_k;
    logic [1:0]       rep_k;
    logic             order_ok;
    logic             seq_bad;

    // Frame assembly state
    state_t           state_q, state_d;
    logic [3:0][3:0]  shd_val_q, shd_val_d;
    logic [3:0]       shd_dp_q, shd_dp_d;
    logic [3:0][3:0]  out_val_q, out_val_d;
    logic [3:0]       out_dp_q, out_dp_d;
    logic             fv_q, fv_d;
    logic             seg_err_q, seg_err_d;
    logic             seq_err_q, seq_err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_pulse_q, tmo_pulse_d;

    // Stage 0: register the raw bus; everything downstream sees only this copy.
    always_ff @(posedge clk) begin
        an_q   <= {an3, an2, an1, an0};
        seg_q  <= {A, B, C, D, E, F, G};
        dp_q   <= dp;
        prev_q <= sample;
    end

    assign sample = {an_q, seg_q, dp_q};

    // Stage 1: settle counter. A zero count means "no previous sample" (right
    // after reset), so the first sample always starts a fresh interval.
    always_comb begin
        changed = (cnt_q == '0) || (sample != prev_q);
        if (changed) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < SETTLE_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        // Fire only on arrival at the settle count, never while parked there.
        capture = (cnt_d == SETTLE_CNT) && (changed || (cnt_q != SETTLE_CNT));
    end

    always_comb begin
        an_blank = 1'b0;
        an_multi = 1'b0;
        an_k     = 2'd0;
        case (an_q)
            4'b1111: an_blank = 1'b1;
            4'b0111: an_k     = 2'd3;
            4'b1011: an_k     = 2'd2;
            4'b1101: an_k     = 2'd1;
            4'b1110: an_k     = 2'd0;
            default: an_multi = 1'b1;
        endcase
    end

    assign dec     = seg_decode(seg_q);
    assign seg_ok  = dec[4];
    assign seg_val = dec[3:0];
    assign dp_lit  = ~dp_q;

    // Per state: the digit that advances the scan and the digit just stored
    // (a repeat of it is tolerated). An an3 capture is always a legal restart.
    always_comb begin
        exp_k = 2'd3;
        rep_k = 2'd3;
        case (state_q)
            ST_EXP2: begin exp_k = 2'd2; rep_k = 2'd3; end
            ST_EXP1: begin exp_k = 2'd1; rep_k = 2'd2; end
            ST_EXP0: begin exp_k = 2'd0; rep_k = 2'd1; end
            ST_EXP3: begin exp_k = 2'd3; rep_k = 2'd0; end
            default: begin exp_k = 2'd3; rep_k = 2'd3; end
        endcase
    end

    assign order_ok = (an_k == 2'd3) || (an_k == exp_k) || (an_k == rep_k);
    // While hunting for an3, other single digits are simply skipped.
    assign seq_bad  = an_multi || ((state_q != ST_SYNC) && !order_ok);

    always_comb begin
        state_d   = state_q;
        shd_val_d = shd_val_q;
        shd_dp_d  = shd_dp_q;
        out_val_d = out_val_q;
        out_dp_d  = out_dp_q;
        fv_d      = 1'b0;
        seg_err_d = 1'b0;
        seq_err_d = 1'b0;

        if (capture && !an_blank) begin
            seg_err_d = !seg_ok;
            seq_err_d = seq_bad;
            if (!seg_ok || seq_bad) begin
                // Any error drops the partial frame; shadow stays untouched.
                state_d = ST_SYNC;
            end else if (an_k == 2'd3) begin
                shd_val_d[3] = seg_val;
                shd_dp_d[3]  = dp_lit;
                state_d      = ST_EXP2;
            end else if ((state_q != ST_SYNC) && (state_q != ST_EXP3)) begin
                // Either the expected digit or a repeat of the previous one;
                // both overwrite the shadow, only the expected one advances.
                shd_val_d[an_k] = seg_val;
                shd_dp_d[an_k]  = dp_lit;
                if (an_k == exp_k) begin
                    case (state_q)
                        ST_EXP2: state_d = ST_EXP1;
                        ST_EXP1: state_d = ST_EXP0;
                        default: begin
                            out_val_d = shd_val_d;
                            out_dp_d  = shd_dp_d;
                            fv_d      = 1'b1;
                            state_d   = ST_EXP3;
                        end
                    endcase
                end
            end
            // EXP3 with a repeated an0, or SYNC with a non-an3 digit: ignored.
        end
    end

    // Timeout counter runs freely and restarts on every published frame.
    always_comb begin
        tmo_d       = tmo_q + TMO_W'(1);
        tmo_pulse_d = 1'b0;
        if (fv_d) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d       = '0;
            tmo_pulse_d = 1'b1;
        end
    end

    // Stage 2: registered FSM, shadow and outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            state_q     <= ST_SYNC;
            shd_val_q   <= '0;
            shd_dp_q    <= '0;
            out_val_q   <= '0;
            out_dp_q    <= '0;
            fv_q        <= 1'b0;
            seg_err_q   <= 1'b0;
            seq_err_q   <= 1'b0;
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            shd_val_q   <= shd_val_d;
            shd_dp_q    <= shd_dp_d;
            out_val_q   <= out_val_d;
            out_dp_q    <= out_dp_d;
            fv_q        <= fv_d;
            seg_err_q   <= seg_err_d;
            seq_err_q   <= seq_err_d;
            tmo_q       <= tmo_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign digit3      = out_val_q[3];
    assign digit2      = out_val_q[2];
    assign digit1      = out_val_q[1];
    assign digit0      = out_val_q[0];
    assign frame_dp    = out_dp_q;
    assign frame_valid = fv_q;
    assign seg_err     = seg_err_q;
    assign seq_err     = seq_err_q;
    assign timeout     = tmo_pulse_q;

endmodule

// File: tb/tb_four_digit_scan_decoder.sv
// -----------------------------------------------------------------------------
// Bench for four_digit_scan_decoder. Stimulus tasks drive the display bus one
// cycle at a time and feed the same cycle to a reference model. The model
// reasons about stable runs of the bus and scan positions. It pushes every
// frame / error it predicts into a queue. A monitor pops that queue whenever
// the DUT pulses an output and predicts timeouts from the cycle distance to
// the last frame or reset.
// -----------------------------------------------------------------------------
module tb_four_digit_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] an_drv;
    logic [6:0] seg_drv;
    logic       dp_drv;
    logic [3:0] digit3, digit2, digit1, digit0, frame_dp;
    logic       frame_valid, seg_err, seq_err, timeout;

    four_digit_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .an3        (an_drv[3]),
        .an2        (an_drv[2]),
        .an1        (an_drv[1]),
        .an0        (an_drv[0]),
        .A          (seg_drv[6]),
        .B          (seg_drv[5]),
        .C          (seg_drv[4]),
        .D          (seg_drv[3]),
        .E          (seg_drv[2]),
        .F          (seg_drv[1]),
        .G          (seg_drv[0]),
        .dp         (dp_drv),
        .digit3     (digit3),
        .digit2     (digit2),
        .digit1     (digit1),
        .digit0     (digit0),
        .frame_dp   (frame_dp),
        .frame_valid(frame_valid),
        .seg_err    (seg_err),
        .seq_err    (seq_err),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Glyphs for hex 0..F, A..G active-low, A = MSB.
    logic [6:0] seg_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct packed {
        logic        fv;
        logic        se;
        logic        qe;
        logic [15:0] digs;
        logic [3:0]  dps;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // Reference model state
    logic [11:0] m_prev = 12'hFFF;
    int          m_run  = 1;
    bit          m_sync = 1'b0;
    int          m_exp  = 3;
    int          m_last = 3;
    logic [3:0]  m_val [4];
    logic        m_dp  [4];
    logic [15:0] m_frame_digs = 16'h0;
    logic [3:0]  m_frame_dps  = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_ev(input logic fv, input logic se, input logic qe,
                           input logic [15:0] d, input logic [3:0] p);
        ev_t e;
        e.fv = fv; e.se = se; e.qe = qe; e.digs = d; e.dps = p;
        exp_q.push_back(e);
    endtask

    // A stable capture of one bus pattern, judged by scan position.
    task automatic model_capture(input logic [3:0] an, input logic [6:0] seg, input logic dpn);
        int         k;
        bit         onecold;
        bit         ok;
        logic [3:0] v;
        logic [3:0] m;
        bit         seq;
        if (an == 4'hF) return;
        onecold = 1'b0; k = 0;
        for (int i = 0; i < 4; i++) begin
            m = 4'hF; m[i] = 1'b0;
            if (an == m) begin onecold = 1'b1; k = i; end
        end
        ok = 1'b0; v = 4'h0;
        for (int i = 0; i < 16; i++) if (seg == seg_tbl[i]) begin ok = 1'b1; v = 4'(i); end
        seq = !onecold || (m_sync && !(k == 3 || k == m_exp || k == m_last));
        if (seq || !ok) begin
            push_ev(1'b0, !ok, seq, 16'h0, 4'h0);
            m_sync = 1'b0;
            return;
        end
        if (k == 3) begin
            m_val[3] = v; m_dp[3] = !dpn;
            m_sync = 1'b1; m_exp = 2; m_last = 3;
        end else if (!m_sync || m_exp == 3) begin
            // hunting for digit 3, or digit 0 repeated after a finished frame
        end else begin
            m_val[k] = v; m_dp[k] = !dpn;
            if (k == m_exp) begin
                m_last = k;
                if (k == 0) begin
                    m_frame_digs = {m_val[3], m_val[2], m_val[1], m_val[0]};
                    m_frame_dps  = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                    push_ev(1'b1, 1'b0, 1'b0, m_frame_digs, m_frame_dps);
                    m_exp = 3;
                end else begin
                    m_exp = k - 1;
                end
            end
        end
    endtask

    task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input logic dpn);
        logic [11:0] p;
        p = {an, seg, dpn};
        if (p == m_prev) m_run++;
        else begin m_run = 1; m_prev = p; end
        if (m_run == SETTLE) model_capture(an, seg, dpn);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dpn, input int len);
        for (int i = 0; i < len; i++) begin
            an_drv = an; seg_drv = seg; dp_drv = dpn;
            model_step(an, seg, dpn);
            @(posedge clk); #1;
        end
    endtask

    task automatic blank(input int len);
        drive(4'hF, 7'h7F, 1'b1, len);
    endtask

    function automatic logic [3:0] onecold_of(input int k);
        logic [3:0] m;
        m = 4'hF; m[k] = 1'b0;
        return m;
    endfunction

    task automatic digit(input int k, input logic [3:0] v, input logic lit, input int len, input int gap);
        drive(onecold_of(k), seg_tbl[v], !lit, len);
        blank(gap);
    endtask

    task automatic scan_frame(input logic [15:0] d, input logic [3:0] lits, input int len, input int gap);
        for (int k = 3; k >= 0; k--) digit(k, d[k*4 +: 4], lits[k], len, gap);
    endtask

    task automatic do_reset(input int n);
        reset  = 1'b1;
        m_sync = 1'b0;
        blank(n);
        reset  = 1'b0;
    endtask

    // Monitor: reset behaviour, event scoreboard and timeout spacing.
    int  cyc      = 0;
    int  last_ref = 0;
    bit  rst_seen;
    bit  exp_tmo;
    ev_t e;
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_seen = reset;
            @(negedge clk);
            if (rst_seen) begin
                last_ref = cyc;
                check("reset_outputs",
                      {digit3, digit2, digit1, digit0, frame_dp,
                       frame_valid, seg_err, seq_err, timeout}, 32'h0);
            end else begin
                exp_tmo = !frame_valid && ((cyc - last_ref) == TIMEOUT);
                if (exp_tmo || timeout) check("timeout_pulse", timeout, exp_tmo);
                if (frame_valid || exp_tmo) last_ref = cyc;
                if (frame_valid || seg_err || seq_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", {frame_valid, seg_err, seq_err}, 3'b000);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_flags", {frame_valid, seg_err, seq_err}, {e.fv, e.se, e.qe});
                        if (e.fv) begin
                            check("frame_digits", {digit3, digit2, digit1, digit0}, e.digs);
                            check("frame_dp", frame_dp, e.dps);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] rd;
        logic [3:0]  rl;
        reset = 1'b1;
        an_drv = 4'hF; seg_drv = 7'h7F; dp_drv = 1'b1;
        do_reset(4);
        blank(3);

        // 1: clean "1234" twice
        scan_frame(16'h1234, 4'b0000, 8, 2);
        scan_frame(16'h1234, 4'b0000, 8, 2);

        // 2: short glitch on an2 is never captured
        digit(3, 4'h9, 1'b1, 8, 2);
        drive(onecold_of(2), seg_tbl[6], 1'b1, 8);
        drive(onecold_of(2), seg_tbl[8], 1'b1, 2);
        blank(2);
        digit(1, 4'h0, 1'b0, 8, 2);
        digit(0, 4'hF, 1'b1, 8, 2);

        // 3: out-of-order scan 3,1,2,0 then a clean scan
        digit(3, 4'h3, 1'b0, 8, 2);
        digit(1, 4'h1, 1'b0, 8, 2);
        digit(2, 4'h2, 1'b0, 8, 2);
        digit(0, 4'h0, 1'b0, 8, 2);
        scan_frame(16'hC0DE, 4'b1010, 8, 2);

        // 4: multi-hot anodes, then an undecodable an1 pattern
        drive(4'b1100, seg_tbl[8], 1'b1, 8);
        blank(2);
        digit(3, 4'h7, 1'b0, 8, 2);
        digit(2, 4'h6, 1'b0, 8, 2);
        drive(onecold_of(1), 7'h7F, 1'b1, 8);
        blank(2);
        digit(0, 4'h5, 1'b0, 8, 2);
        scan_frame(16'hBEEF, 4'b0001, 8, 2);

        // random frames with occasional bus noise
        for (int f = 0; f < 25; f++) begin
            rd = 16'($urandom);
            rl = 4'($urandom);
            if ($urandom_range(0, 3) == 0)
                drive(4'($urandom), 7'($urandom), 1'($urandom), $urandom_range(1, 6));
            for (int k = 3; k >= 0; k--)
                digit(k, rd[k*4 +: 4], rl[k], $urandom_range(SETTLE, 10), $urandom_range(0, 3));
        end

        // 5: bus goes idle, timeouts repeat and the last frame is held
        scan_frame(16'h5A7E, 4'b0110, 8, 2);
        blank(2 * TIMEOUT + 100);
        check("hold_digits", {digit3, digit2, digit1, digit0}, m_frame_digs);
        check("hold_dp", frame_dp, m_frame_dps);

        // 6: reset after digits 3 and 2, then "ABCD"
        digit(3, 4'h3, 1'b0, 8, 2);
        digit(2, 4'h2, 1'b0, 8, 6);
        do_reset(3);
        blank(3);
        digit(1, 4'h9, 1'b0, 8, 2);
        digit(0, 4'h9, 1'b0, 8, 2);
        scan_frame(16'hABCD, 4'b0000, 8, 2);

        blank(20);
        check("all_events_seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
